// File: rtl/seven_seg_bcd_decoder_if.sv
// Segment readback bus: raw segment pattern in, registered BCD digit, error flag and error count out.
interface seven_seg_bcd_decoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic [6:0]           seg_in;
    logic                 in_valid;
    logic [3:0]           bcd_out;
    logic                 out_valid;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output seg_in, in_valid,
        input  bcd_out, out_valid, err, err_count
    );

    modport slave (
        input  seg_in, in_valid,
        output bcd_out, out_valid, err, err_count
    );
endinterface

// File: rtl/seven_seg_bcd_decoder.sv
// Decodes a 7-segment pattern {a..g} back to a BCD digit; unknown glyphs give 4'hF and bump a saturating counter.
// One cycle latency, accepts a new pattern every cycle; no backpressure.
module seven_seg_bcd_decoder #(
    parameter int ACTIVE_LOW = 1,
    parameter int ALT_GLYPHS = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    seven_seg_bcd_decoder_if.slave bus
);

    logic [6:0] lit;
    logic [3:0] dec_digit;
    logic       dec_err;

    always_comb begin
        lit       = (ACTIVE_LOW != 0) ? ~bus.seg_in : bus.seg_in;
        dec_digit = 4'hF;
        dec_err   = 1'b0;
        // Exact match on the active-high pattern; anything else is an error.
        case (lit)
            7'b1111110: dec_digit = 4'd0;
            7'b0110000: dec_digit = 4'd1;
            7'b1101101: dec_digit = 4'd2;
            7'b1111001: dec_digit = 4'd3;
            7'b0110011: dec_digit = 4'd4;
            7'b1011011: dec_digit = 4'd5;
            7'b1011111: dec_digit = 4'd6;
            7'b1110000: dec_digit = 4'd7;
            7'b1111111: dec_digit = 4'd8;
            7'b1111011: dec_digit = 4'd9;
            7'b0011111: begin
                if (ALT_GLYPHS != 0) dec_digit = 4'd6;
                else                 dec_err   = 1'b1;
            end
            7'b1110010: begin
                if (ALT_GLYPHS != 0) dec_digit = 4'd7;
                else                 dec_err   = 1'b1;
            end
            7'b1110011: begin
                if (ALT_GLYPHS != 0) dec_digit = 4'd9;
                else                 dec_err   = 1'b1;
            end
            default:    dec_err = 1'b1;
        endcase
        if (dec_err) dec_digit = 4'hF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bcd_out   <= 4'd0;
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
            bus.err_count <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.bcd_out <= dec_digit;
                bus.err     <= dec_err;
                if (dec_err && (bus.err_count != {ERR_CNT_W{1'b1}}))
                    bus.err_count <= bus.err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_bcd_decoder.sv
// Scoreboard bench: three decoder configurations see the same stimulus and are checked against a reference model.
module tb_seven_seg_bcd_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // d0: active-low + alt glyphs, d1: active-low canonical only, d2: active-high + alt glyphs
    seven_seg_bcd_decoder_if #(.ERR_CNT_W(8)) if0 ();
    seven_seg_bcd_decoder_if #(.ERR_CNT_W(8)) if1 ();
    seven_seg_bcd_decoder_if #(.ERR_CNT_W(8)) if2 ();

    seven_seg_bcd_decoder #(.ACTIVE_LOW(1), .ALT_GLYPHS(1), .ERR_CNT_W(8)) u_d0 (.clk(clk), .rst(rst), .bus(if0.slave));
    seven_seg_bcd_decoder #(.ACTIVE_LOW(1), .ALT_GLYPHS(0), .ERR_CNT_W(8)) u_d1 (.clk(clk), .rst(rst), .bus(if1.slave));
    seven_seg_bcd_decoder #(.ACTIVE_LOW(0), .ALT_GLYPHS(1), .ERR_CNT_W(8)) u_d2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [3:0] act_bcd [3];
    logic       act_vld [3];
    logic       act_err [3];
    logic [7:0] act_cnt [3];

    assign act_bcd[0] = if0.bcd_out;  assign act_vld[0] = if0.out_valid;
    assign act_err[0] = if0.err;      assign act_cnt[0] = if0.err_count;
    assign act_bcd[1] = if1.bcd_out;  assign act_vld[1] = if1.out_valid;
    assign act_err[1] = if1.err;      assign act_cnt[1] = if1.err_count;
    assign act_bcd[2] = if2.bcd_out;  assign act_vld[2] = if2.out_valid;
    assign act_err[2] = if2.err;      assign act_cnt[2] = if2.err_count;

    typedef struct packed {
        logic [31:0]     due;
        logic            vld;
        logic [2:0][3:0] bcd;
        logic [2:0]      err;
        logic [2:0][7:0] cnt;
    } sb_t;

    sb_t sb_q [$];

    logic [3:0] m_bcd [3];
    logic       m_err [3];
    logic [7:0] m_cnt [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference decode written against the active-low code table; returns {err, digit}.
    function automatic logic [4:0] ref_decode(input logic [6:0] s, input bit al, input bit alt);
        logic [6:0] c;
        c = al ? s : ~s;
        case (c)
            7'b0000001: return {1'b0, 4'd0};
            7'b1001111: return {1'b0, 4'd1};
            7'b0010010: return {1'b0, 4'd2};
            7'b0000110: return {1'b0, 4'd3};
            7'b1001100: return {1'b0, 4'd4};
            7'b0100100: return {1'b0, 4'd5};
            7'b0100000: return {1'b0, 4'd6};
            7'b0001111: return {1'b0, 4'd7};
            7'b0000000: return {1'b0, 4'd8};
            7'b0000100: return {1'b0, 4'd9};
            7'b1100000: return alt ? {1'b0, 4'd6} : {1'b1, 4'hF};
            7'b0001101: return alt ? {1'b0, 4'd7} : {1'b1, 4'hF};
            7'b0001100: return alt ? {1'b0, 4'd9} : {1'b1, 4'hF};
            default:    return {1'b1, 4'hF};
        endcase
    endfunction

    task automatic drive(input logic r, input logic [6:0] s, input logic v);
        sb_t        e;
        logic [4:0] res;
        bit         al [3];
        bit         alt [3];
        al[0] = 1; alt[0] = 1;
        al[1] = 1; alt[1] = 0;
        al[2] = 0; alt[2] = 1;
        @(posedge clk);
        #1;
        rst = r;
        if0.seg_in = s; if0.in_valid = v;
        if1.seg_in = s; if1.in_valid = v;
        if2.seg_in = s; if2.in_valid = v;
        for (int d = 0; d < 3; d++) begin
            if (r) begin
                m_bcd[d] = 4'd0; m_err[d] = 1'b0; m_cnt[d] = 8'd0;
            end else if (v) begin
                res = ref_decode(s, al[d], alt[d]);
                m_bcd[d] = res[3:0];
                m_err[d] = res[4];
                if (res[4] && m_cnt[d] != 8'hFF) m_cnt[d] = m_cnt[d] + 8'd1;
            end
            e.bcd[d] = m_bcd[d];
            e.err[d] = m_err[d];
            e.cnt[d] = m_cnt[d];
        end
        e.vld = v && !r;
        e.due = cyc + 1;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        sb_t e;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("d%0d_out_valid", d), {31'd0, act_vld[d]}, {31'd0, e.vld});
                chk($sformatf("d%0d_bcd_out", d),   {28'd0, act_bcd[d]}, {28'd0, e.bcd[d]});
                chk($sformatf("d%0d_err", d),       {31'd0, act_err[d]}, {31'd0, e.err[d]});
                chk($sformatf("d%0d_err_count", d), {24'd0, act_cnt[d]}, {24'd0, e.cnt[d]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout queue=%0d", sb_q.size());
        $fatal(1, "timeout");
    end

    logic [6:0] canon [10];

    initial begin
        canon[0] = 7'b0000001; canon[1] = 7'b1001111; canon[2] = 7'b0010010;
        canon[3] = 7'b0000110; canon[4] = 7'b1001100; canon[5] = 7'b0100100;
        canon[6] = 7'b0100000; canon[7] = 7'b0001111; canon[8] = 7'b0000000;
        canon[9] = 7'b0000100;
        for (int d = 0; d < 3; d++) begin
            m_bcd[d] = 4'd0; m_err[d] = 1'b0; m_cnt[d] = 8'd0;
        end
        if0.seg_in = 7'b0000001; if0.in_valid = 1'b1;
        if1.seg_in = 7'b0000001; if1.in_valid = 1'b1;
        if2.seg_in = 7'b0000001; if2.in_valid = 1'b1;

        // reset held with in_valid asserted
        drive(1'b1, 7'b0000001, 1'b1);
        drive(1'b1, 7'b0000001, 1'b1);

        for (int i = 0; i < 10; i++) drive(1'b0, canon[i], 1'b1);

        drive(1'b0, 7'b1111111, 1'b1);
        drive(1'b0, 7'b0000001, 1'b1);

        drive(1'b0, 7'b1100000, 1'b1);
        drive(1'b0, 7'b0001101, 1'b1);
        drive(1'b0, 7'b0001100, 1'b1);

        drive(1'b0, 7'b0110000, 1'b1);
        drive(1'b0, 7'b1111111, 1'b1);

        // a bubble between bursts, then an error burst long enough to saturate
        drive(1'b0, 7'b0000001, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b0, 7'b0110110, 1'b1);

        drive(1'b0, 7'b0000001, 1'b0);
        drive(1'b0, 7'b0000001, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drain", sb_q.size(), 32'd0);
        chk("d0_saturated", {24'd0, m_cnt[0]}, 32'd255);
        chk("d1_saturated", {24'd0, m_cnt[1]}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
